// File: rtl/dmem_dma.sv
// Block COPY / FILL / CMP engine mastering both ports of the dual-port dmem.
// One word per clock; start/busy/done handshake, addresses wrap mod 2**AW.
module dmem_dma #(
   parameter int AW = 9,
   parameter int DW = 32
) (
   input  logic          ck,
   input  logic          rst,
   input  logic          start,
   input  logic [1:0]    mode,
   input  logic [AW-1:0] src,
   input  logic [AW-1:0] dst,
   input  logic [AW:0]   len,
   input  logic [DW-1:0] fill_val,
   output logic          busy,
   output logic          done,
   output logic          mismatch,
   output logic [AW-1:0] mis_idx,
   output logic          cena,
   output logic          wena,
   output logic [AW-1:0] adra,
   output logic [DW-1:0] inpa,
   input  logic [DW-1:0] outa,
   output logic          cenb,
   output logic          wenb,
   output logic [AW-1:0] adrb,
   output logic [DW-1:0] inpb,
   input  logic [DW-1:0] outb
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   typedef enum logic [1:0] {
      M_COPY = 2'd0,
      M_FILL = 2'd1,
      M_CMP  = 2'd2,
      M_RSVD = 2'd3
   } mode_t;

   localparam logic [AW:0]   ONE_L = 1;
   localparam logic [AW-1:0] ONE_A = 1;

   state_t        state, state_n;
   mode_t         mode_r;
   logic [AW-1:0] src_r, dst_r;
   logic [AW:0]   len_r, cnt;
   logic [DW-1:0] fill_r;
   logic          desc_r;

   logic [AW-1:0] diff, last_off, off;
   logic          accept, go_run, overlap, last_word, cmp_hit;

   always_comb begin
      accept    = (state == IDLE) && start;
      go_run    = (len != '0) && (mode_t'(mode) != M_RSVD);
      diff      = dst - src;
      // Destination starting inside the source window: walk top-down so every
      // source word is read before it can be overwritten.
      overlap   = (dst != src) && ({1'b0, diff} < len);
      last_off  = len_r[AW-1:0] - ONE_A;
      off       = desc_r ? (last_off - cnt[AW-1:0]) : cnt[AW-1:0];
      last_word = (cnt == len_r - ONE_L);
      cmp_hit   = (state == RUN) && (mode_r == M_CMP) && (outa != outb);
   end

   always_ff @(posedge ck) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = go_run ? RUN : DONE;
         RUN:     if (last_word || cmp_hit) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge ck) begin
      if (rst) begin
         mode_r   <= M_COPY;
         src_r    <= '0;
         dst_r    <= '0;
         len_r    <= '0;
         fill_r   <= '0;
         desc_r   <= 1'b0;
         cnt      <= '0;
         mismatch <= 1'b0;
         mis_idx  <= '0;
      end else if (accept) begin
         mode_r   <= mode_t'(mode);
         src_r    <= src;
         dst_r    <= dst;
         len_r    <= len;
         fill_r   <= fill_val;
         desc_r   <= overlap && (mode_t'(mode) == M_COPY);
         cnt      <= '0;
         mismatch <= 1'b0;
         mis_idx  <= '0;
      end else if (state == RUN) begin
         cnt <= cnt + ONE_L;
         if (cmp_hit) begin
            mismatch <= 1'b1;
            mis_idx  <= off;
         end
      end
   end

   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
      cena = 1'b0;
      wena = 1'b0;
      cenb = 1'b0;
      wenb = 1'b0;
      adra = '0;
      adrb = '0;
      inpa = '0;
      inpb = '0;
      if (state == RUN) begin
         adra = src_r + off;
         adrb = dst_r + off;
         // A reset edge aborts the transfer before the in-flight word commits.
         cena = !rst && (mode_r != M_FILL);
         cenb = !rst;
         wenb = !rst && (mode_r != M_CMP);
         case (mode_r)
            M_COPY:  inpb = outa;
            M_FILL:  inpb = fill_r;
            default: inpb = '0;
         endcase
      end
   end

endmodule
